br_ram_rd_data_combiner_stage: RTL and testbench

Read-return side of a banked RAM: counterpart to the address decoder stage that fans a request out to one of `Forks` banks. It records, in a delay line, which fork each read request was sent to. When the bank data returns `ReadLatency` cycles later, it selects that fork's data onto a single output, optionally through an output register. It also flags any protocol violation: a missing response, a response from the wrong fork, or a response with no request behind it. There is no backpressure; full throughput is one read per cycle.

---
 rtl/br_ram_rd_data_combiner_stage.sv | 94 +++++++++
 tb/tb_br_ram_rd_data_combiner_stage.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/br_ram_rd_data_combiner_stage.sv
// br_ram_rd_data_combiner_stage: steers returning bank read data onto one output and flags protocol errors
module br_ram_rd_data_combiner_stage #(
  parameter int Forks = 1,
  parameter int DataWidth = 1,
  parameter int ReadLatency = 1,
  parameter int RegisterOutputs = 0,
  localparam int ForkSelectWidth = Forks == 1 ? 1 : $clog2(Forks)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  input  logic [ForkSelectWidth-1:0]          req_fork_sel,
  input  logic [Forks-1:0]                    in_valid,
  input  logic [Forks-1:0][DataWidth-1:0]     in_data,
  output logic                                out_valid,
  output logic [DataWidth-1:0]                out_data,
  output logic                                out_error,
  output logic                                error_seen
);
  localparam int TotalLatency = ReadLatency + RegisterOutputs;
  logic                       w_exp_valid;
  logic [ForkSelectWidth-1:0] w_exp_sel;
  logic [ForkSelectWidth-1:0] w_sel;
  logic [Forks-1:0]           w_exp_onehot;
  logic [Forks-1:0]           w_hit_vec;
  logic                       w_valid;
  logic                       w_error;
  logic [DataWidth-1:0]       w_data;
  logic                       r_error_seen;
  if (ReadLatency == 0) begin : g_no_delay
    assign w_exp_valid = req_valid;
    assign w_exp_sel   = req_fork_sel;
  end else begin : g_delay
    logic [ReadLatency-1:0]                      r_exp_valid;
    logic [ReadLatency-1:0][ForkSelectWidth-1:0] r_exp_sel;
    always_ff @(posedge clk) begin
      if (rst) r_exp_valid <= '0;
      else begin
        r_exp_valid[0] <= req_valid;
        for (int i = 1; i < ReadLatency; i++) r_exp_valid[i] <= r_exp_valid[i-1];
      end
    end
    // Select bits need no reset: they are qualified by r_exp_valid
    always_ff @(posedge clk) begin
      r_exp_sel[0] <= req_fork_sel;
      for (int i = 1; i < ReadLatency; i++) r_exp_sel[i] <= r_exp_sel[i-1];
    end
    assign w_exp_valid = r_exp_valid[ReadLatency-1];
    assign w_exp_sel   = r_exp_sel[ReadLatency-1];
  end
  assign w_sel        = Forks == 1 ? '0 : w_exp_sel;
  assign w_exp_onehot = w_exp_valid ? Forks'(1) << w_sel : '0;
  assign w_hit_vec    = in_valid & w_exp_onehot;
  assign w_valid      = |w_hit_vec;
  assign w_error      = (w_exp_valid & ~w_valid) | (|(in_valid & ~w_exp_onehot));
  always_comb begin
    w_data = '0;
    for (int i = 0; i < Forks; i++) w_data = w_data | (in_data[i] & {DataWidth{w_hit_vec[i]}});
  end
  if (RegisterOutputs != 0) begin : g_reg_out
    logic                 r_out_valid;
    logic                 r_out_error;
    logic [DataWidth-1:0] r_out_data;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_out_error <= 1'b0;
        r_out_data  <= '0;
      end else begin
        r_out_valid <= w_valid;
        r_out_error <= w_error;
        r_out_data  <= w_data;
      end
    end
    assign out_valid = r_out_valid;
    assign out_error = r_out_error;
    assign out_data  = r_out_data;
  end else begin : g_comb_out
    assign out_valid = w_valid;
    assign out_error = w_error;
    assign out_data  = w_data;
  end
  always_ff @(posedge clk) begin
    if (rst) r_error_seen <= 1'b0;
    else r_error_seen <= r_error_seen | out_error;
  end
  assign error_seen = r_error_seen;
  if (TotalLatency == 0) begin : g_chk_comb
    a_valid_has_req: assert property (@(posedge clk) disable iff (rst) out_valid |-> req_valid);
  end else begin : g_chk_seq
    a_valid_has_req: assert property (@(posedge clk) disable iff (rst) out_valid |-> $past(req_valid, TotalLatency));
  end
  a_error_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(out_error));
endmodule

// File: tb/tb_br_ram_rd_data_combiner_stage.sv
// tb_br_ram_rd_data_combiner_stage: directed checks of a 4-fork registered config and a 1-fork combinational config
module tb_br_ram_rd_data_combiner_stage;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  logic            a_req_valid;
  logic [1:0]      a_req_fork_sel;
  logic [3:0]      a_in_valid;
  logic [3:0][7:0] a_in_data;
  logic            a_out_valid;
  logic [7:0]      a_out_data;
  logic            a_out_error;
  logic            a_error_seen;
  logic            b_req_valid;
  logic            b_req_fork_sel;
  logic            b_in_valid;
  logic [7:0]      b_in_data;
  logic            b_out_valid;
  logic [7:0]      b_out_data;
  logic            b_out_error;
  logic            b_error_seen;
  br_ram_rd_data_combiner_stage #(.Forks(4), .DataWidth(8), .ReadLatency(2), .RegisterOutputs(1)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_fork_sel(a_req_fork_sel),
    .in_valid(a_in_valid), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_error(a_out_error), .error_seen(a_error_seen)
  );
  br_ram_rd_data_combiner_stage #(.Forks(1), .DataWidth(8), .ReadLatency(0), .RegisterOutputs(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_fork_sel(b_req_fork_sel),
    .in_valid(b_in_valid), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_error(b_out_error), .error_seen(b_error_seen)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Drive one cycle of fork-A inputs, then land 1ns after the next edge
  task automatic cyc(input logic rv, input logic [1:0] sel, input logic [3:0] iv, input logic [31:0] d);
    a_req_valid    = rv;
    a_req_fork_sel = sel;
    a_in_valid     = iv;
    a_in_data      = d;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic v, input logic [7:0] d, input logic e);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, ".data"}, 32'(a_out_data), 32'(d));
    chk({tag, ".error"}, 32'(a_out_error), 32'(e));
  endtask
  initial begin
    rst = 1'b1;
    b_req_valid = 1'b0; b_req_fork_sel = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_a("reset", 0, 0, 0);
    chk("reset.seen", 32'(a_error_seen), 0);
    rst = 1'b0;
    // basic select
    cyc(1, 2, 0, 0);
    cyc(0, 0, 0, 0);
    chk_a("basic.c2", 0, 0, 0);
    cyc(0, 0, 4'b0100, 32'h00A5_0000);
    chk_a("basic.c3", 1, 8'hA5, 0);
    cyc(0, 0, 0, 0);
    chk_a("basic.c4", 0, 0, 0);
    // streaming over all forks
    for (int i = 0; i < 6; i++) begin
      cyc(i < 4, 2'(i), i >= 2 ? 4'(1 << (i - 2)) : 4'b0, i >= 2 ? 32'((32'h10 + i - 2) << (8 * (i - 2))) : 32'h0);
      if (i >= 2) chk_a($sformatf("stream%0d", i - 2), 1, 8'(8'h10 + i - 2), 0);
    end
    cyc(0, 0, 0, 0);
    chk_a("stream.end", 0, 0, 0);
    chk("stream.seen", 32'(a_error_seen), 0);
    // wrong fork
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 4'b1000, 32'h7700_0000);
    chk_a("wrong", 0, 0, 1);
    chk("wrong.seen0", 32'(a_error_seen), 0);
    cyc(0, 0, 0, 0);
    chk("wrong.seen1", 32'(a_error_seen), 1);
    chk("wrong.pulse", 32'(a_out_error), 0);
    cyc(0, 0, 0, 0);
    chk("wrong.seen2", 32'(a_error_seen), 1);
    // missing response
    cyc(1, 3, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_a("missing", 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("missing.pulse", 32'(a_out_error), 0);
    // spurious response
    cyc(0, 0, 4'b0001, 32'h0000_0005);
    chk_a("spurious", 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("spurious.pulse", 32'(a_out_error), 0);
    // double response still delivers expected data
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 4'b0011, 32'h0000_3C5A);
    chk_a("double", 1, 8'h5A, 1);
    cyc(0, 0, 0, 0);
    // reset mid-flight
    cyc(1, 1, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    chk_a("midrst", 0, 0, 0);
    chk("midrst.seen", 32'(a_error_seen), 0);
    rst = 1'b0;
    cyc(0, 0, 4'b0010, 32'h0000_9900);
    chk_a("late", 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("late.seen", 32'(a_error_seen), 1);
    // single fork, zero latency, combinational output
    chk("b.reset.seen", 32'(b_error_seen), 0);
    b_req_valid = 1'b1; b_in_valid = 1'b1; b_in_data = 8'hA5;
    #1;
    chk("b.valid", 32'(b_out_valid), 1);
    chk("b.data", 32'(b_out_data), 32'hA5);
    chk("b.error", 32'(b_out_error), 0);
    b_in_valid = 1'b0;
    #1;
    chk("b.miss.valid", 32'(b_out_valid), 0);
    chk("b.miss.data", 32'(b_out_data), 0);
    chk("b.miss.error", 32'(b_out_error), 1);
    @(posedge clk);
    #1;
    b_req_valid = 1'b0;
    #1;
    chk("b.seen", 32'(b_error_seen), 1);
    chk("b.idle.error", 32'(b_out_error), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
